id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
// - ID/EX pipeline stage of the FRiscV RV32I core, directly upstream of the ALU.
// - Registers decoded operands and control; drives the ALU's a_in, b_in and ctrl_in.
// - Selects operands (rs1/PC, rs2/imm), forwards results from later stages, handles handshake, stall and flush.
// PARAMETERS
// - ARCH   32   datapath width (friscv_pkg constant, not overridable per instance)
// - REG_AW  5   register address width
// PORTS
// - clk              in   1     core clock
// - rst              in   1     synchronous active-high reset
// - id_valid_in      in   1     decode has a valid instruction
// - id_ready_out     out  1     stage can accept an instruction this cycle
// - id_pc_in         in   ARCH  PC of the instruction
// - id_rs1_data_in   in   ARCH  register-file read data, rs1
// - id_rs2_data_in   in   ARCH  register-file read data, rs2
// - id_imm_in        in   ARCH  sign-extended immediate
// - id_rs1_addr_in   in   5     rs1 index
// - id_rs2_addr_in   in   5     rs2 index
// - id_rd_addr_in    in   5     rd index
// - id_alu_ctrl_in   in   4     ALU op, friscv_pkg encoding (AND,OR,XOR,ADD,SUB,SLT,SLL,SAR,SLR)
// - id_a_sel_in      in   1     0: A=rs1, 1: A=PC
// - id_b_sel_in      in   1     0: B=rs2, 1: B=imm
// - id_reg_we_in     in   1     instruction writes rd
// - flush_in         in   1     kill the instruction held in this stage (branch/jump redirect)
// - ex_ready_in      in   1     downstream (EX/MEM) accepts this cycle
// - exm_rd_addr_in   in   5     EX/MEM destination index
// - exm_reg_we_in    in   1     EX/MEM write enable
// - exm_result_in    in   ARCH  EX/MEM ALU result
// - wb_rd_addr_in    in   5     MEM/WB destination index
// - wb_reg_we_in     in   1     MEM/WB write enable
// - wb_data_in       in   ARCH  MEM/WB write-back data
// - ex_valid_out     out  1     stage holds a valid instruction
// - alu_ctrl_out     out  4     to ALU ctrl_in
// - alu_a_out        out  ARCH  to ALU a_in
// - alu_b_out        out  ARCH  to ALU b_in
// - ex_rs2_data_out  out  ARCH  forwarded rs2 value, used as store data
// - ex_pc_out        out  ARCH  registered PC
// - ex_rd_addr_out   out  5     registered rd
// - ex_reg_we_out    out  1     registered we, gated by ex_valid_out
// BEHAVIOUR
// - Reset: all registers cleared. ex_valid_out=0, alu_ctrl_out=4'b0, all data and address outputs 0, ex_reg_we_out=0.
// - Handshake: id_ready_out = !ex_valid_out | ex_ready_in (combinational). Load when id_valid_in & id_ready_out. Latency is 1 cycle.
// - Valid next state, in priority order: rst -> 0; flush_in -> 0 (flush beats a simultaneous load, and the incoming instruction is dropped); load -> 1; ex_ready_in -> 0; otherwise hold.
// - Stall: when ex_valid_out & !ex_ready_in, every register holds.
// - While the stage is empty, data registers may update freely; outputs are don't-care except ex_reg_we_out=0.
// - Forwarding is combinational on the registered rs addresses and is evaluated for rs1 and rs2 each cycle:
//   - EX/MEM match (exm_reg_we_in & exm_rd_addr_in==rsN & rsN!=0) -> exm_result_in;
//   - else MEM/WB match (same rule with wb_*) -> wb_data_in;
//   - else the registered rsN data.
//   - Index 0 is never forwarded; EX/MEM has priority over MEM/WB.
// - alu_a_out = a_sel ? pc : fwd_rs1. alu_b_out = b_sel ? imm : fwd_rs2. ex_rs2_data_out = fwd_rs2 in both cases.
// - Outputs may change during a stall only if the forwarding sources change.
// - Widths: all data paths are ARCH bits; no extension is done in this stage.
// CONFIGURATION
// - FRISCV_FWD_EN defined: forwarding exactly as described above.
// - FRISCV_FWD_EN undefined:
//   - the forwarding input ports remain but are ignored;
//   - rsN data is used unmodified;
//   - hazards are resolved by upstream interlock.
// STRUCTURE
// - friscv_pkg holds ARCH, REG_AW, the alu_ctrl encodings and a typedef id_ex_t.
// - id_ex_t is a packed struct of pc, rs1/rs2 data, imm, rs1/rs2/rd addresses, alu_ctrl, a_sel, b_sel and reg_we.
// - Sub-module fwd_mux: one instance per source operand.
//   - Inputs: rs_addr, rs_data, exm/wb triples.
//   - Output: the forwarded data.
//   - Contains the `ifdef FRISCV_FWD_EN` logic.
// TESTING
// - Reset: hold rst 2 cycles -> ex_valid_out=0, id_ready_out=1, ex_reg_we_out=0, alu_ctrl_out=0.
// - Load: ADD, rs1=5/32'h10, imm=32'h4, b_sel=1, ex_ready_in=1 -> next cycle alu_a_out=32'h10, alu_b_out=32'h4, valid=1.
// - Stall: ex_ready_in=0 with a new id_valid_in -> id_ready_out=0, outputs hold 3 cycles; release -> the new instruction is loaded the cycle after.
// - Flush: flush_in=1 together with id_valid_in=1 -> ex_valid_out=0 next cycle, ex_reg_we_out=0.
// - Forwarding (FWD_EN): rs1=3, exm rd=3 we=1 result=32'hAA, wb rd=3 data=32'hBB -> alu_a_out=32'hAA; exm_we=0 -> 32'hBB.
// - x0 and no-FWD: rs1=0 with exm rd=0 we=1 -> alu_a_out=registered rs1 data. Without FRISCV_FWD_EN, a matching exm -> the raw rs1 data is passed through.

Source files
------------

// File: rtl/friscv_pkg.sv
// Shared FRiscV constants, ALU op encodings and the ID/EX pipeline record.
package friscv_pkg;

    localparam int ARCH   = 32;
    localparam int REG_AW = 5;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_XOR = 4'd2;
    localparam logic [3:0] ALU_ADD = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SAR = 4'd7;
    localparam logic [3:0] ALU_SLR = 4'd8;

    typedef struct packed {
        logic [ARCH-1:0]   pc;
        logic [ARCH-1:0]   rs1_data;
        logic [ARCH-1:0]   rs2_data;
        logic [ARCH-1:0]   imm;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd_addr;
        logic [3:0]        alu_ctrl;
        logic              a_sel;
        logic              b_sel;
        logic              reg_we;
    } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding for one source register (EX/MEM over MEM/WB, x0 never forwarded).
// Forwarding is only built when FRISCV_FWD_EN is defined; otherwise rs_data passes through.
module fwd_mux
    import friscv_pkg::*;
(
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [ARCH-1:0]   rs_data,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic              exm_reg_we,
    input  logic [ARCH-1:0]   exm_result,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic              wb_reg_we,
    input  logic [ARCH-1:0]   wb_data,
    output logic [ARCH-1:0]   fwd_data
);

`ifdef FRISCV_FWD_EN
    logic exm_hit;
    logic wb_hit;

    assign exm_hit = exm_reg_we && (exm_rd_addr == rs_addr) && (rs_addr != '0);
    assign wb_hit  = wb_reg_we  && (wb_rd_addr  == rs_addr) && (rs_addr != '0);

    always_comb begin
        fwd_data = rs_data;
        if (exm_hit) begin
            fwd_data = exm_result;
        end else if (wb_hit) begin
            fwd_data = wb_data;
        end
    end
`else
    // Upstream interlock resolves hazards; the later-stage buses are intentionally ignored.
    logic unused_fwd;
    assign unused_fwd = ^{rs_addr, exm_rd_addr, exm_reg_we, exm_result,
                          wb_rd_addr, wb_reg_we, wb_data};
    assign fwd_data   = rs_data;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the FRiscV core: operand select, forwarding, handshake, stall, flush.
// Forwarding depends on the FRISCV_FWD_EN macro (see fwd_mux).
module id_ex_stage
    import friscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_in,
    output logic              id_ready_out,
    input  logic [ARCH-1:0]   id_pc_in,
    input  logic [ARCH-1:0]   id_rs1_data_in,
    input  logic [ARCH-1:0]   id_rs2_data_in,
    input  logic [ARCH-1:0]   id_imm_in,
    input  logic [REG_AW-1:0] id_rs1_addr_in,
    input  logic [REG_AW-1:0] id_rs2_addr_in,
    input  logic [REG_AW-1:0] id_rd_addr_in,
    input  logic [3:0]        id_alu_ctrl_in,
    input  logic              id_a_sel_in,
    input  logic              id_b_sel_in,
    input  logic              id_reg_we_in,
    input  logic              flush_in,
    input  logic              ex_ready_in,
    input  logic [REG_AW-1:0] exm_rd_addr_in,
    input  logic              exm_reg_we_in,
    input  logic [ARCH-1:0]   exm_result_in,
    input  logic [REG_AW-1:0] wb_rd_addr_in,
    input  logic              wb_reg_we_in,
    input  logic [ARCH-1:0]   wb_data_in,
    output logic              ex_valid_out,
    output logic [3:0]        alu_ctrl_out,
    output logic [ARCH-1:0]   alu_a_out,
    output logic [ARCH-1:0]   alu_b_out,
    output logic [ARCH-1:0]   ex_rs2_data_out,
    output logic [ARCH-1:0]   ex_pc_out,
    output logic [REG_AW-1:0] ex_rd_addr_out,
    output logic              ex_reg_we_out
);

    id_ex_t          stage_q;
    logic            valid_q;
    logic            load;
    logic [ARCH-1:0] fwd_rs1;
    logic [ARCH-1:0] fwd_rs2;

    assign id_ready_out = !valid_q || ex_ready_in;
    assign load         = id_valid_in && id_ready_out;

    // A flushed incoming instruction is dropped entirely, payload included.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            stage_q <= '0;
        end else begin
            if (flush_in) begin
                valid_q <= 1'b0;
            end else if (load) begin
                valid_q <= 1'b1;
            end else if (ex_ready_in) begin
                valid_q <= 1'b0;
            end

            if (load && !flush_in) begin
                stage_q.pc       <= id_pc_in;
                stage_q.rs1_data <= id_rs1_data_in;
                stage_q.rs2_data <= id_rs2_data_in;
                stage_q.imm      <= id_imm_in;
                stage_q.rs1_addr <= id_rs1_addr_in;
                stage_q.rs2_addr <= id_rs2_addr_in;
                stage_q.rd_addr  <= id_rd_addr_in;
                stage_q.alu_ctrl <= id_alu_ctrl_in;
                stage_q.a_sel    <= id_a_sel_in;
                stage_q.b_sel    <= id_b_sel_in;
                stage_q.reg_we   <= id_reg_we_in;
            end
        end
    end

    fwd_mux u_fwd_rs1 (
        .rs_addr     (stage_q.rs1_addr),
        .rs_data     (stage_q.rs1_data),
        .exm_rd_addr (exm_rd_addr_in),
        .exm_reg_we  (exm_reg_we_in),
        .exm_result  (exm_result_in),
        .wb_rd_addr  (wb_rd_addr_in),
        .wb_reg_we   (wb_reg_we_in),
        .wb_data     (wb_data_in),
        .fwd_data    (fwd_rs1)
    );

    fwd_mux u_fwd_rs2 (
        .rs_addr     (stage_q.rs2_addr),
        .rs_data     (stage_q.rs2_data),
        .exm_rd_addr (exm_rd_addr_in),
        .exm_reg_we  (exm_reg_we_in),
        .exm_result  (exm_result_in),
        .wb_rd_addr  (wb_rd_addr_in),
        .wb_reg_we   (wb_reg_we_in),
        .wb_data     (wb_data_in),
        .fwd_data    (fwd_rs2)
    );

    assign ex_valid_out    = valid_q;
    assign alu_ctrl_out    = stage_q.alu_ctrl;
    assign alu_a_out       = stage_q.a_sel ? stage_q.pc  : fwd_rs1;
    assign alu_b_out       = stage_q.b_sel ? stage_q.imm : fwd_rs2;
    assign ex_rs2_data_out = fwd_rs2;
    assign ex_pc_out       = stage_q.pc;
    assign ex_rd_addr_out  = stage_q.rd_addr;
    assign ex_reg_we_out   = valid_q && stage_q.reg_we;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic vs. a transaction model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid_in;
    logic        id_ready_out;
    logic [31:0] id_pc_in, id_rs1_data_in, id_rs2_data_in, id_imm_in;
    logic [4:0]  id_rs1_addr_in, id_rs2_addr_in, id_rd_addr_in;
    logic [3:0]  id_alu_ctrl_in;
    logic        id_a_sel_in, id_b_sel_in, id_reg_we_in;
    logic        flush_in, ex_ready_in;
    logic [4:0]  exm_rd_addr_in, wb_rd_addr_in;
    logic        exm_reg_we_in, wb_reg_we_in;
    logic [31:0] exm_result_in, wb_data_in;
    logic        ex_valid_out;
    logic [3:0]  alu_ctrl_out;
    logic [31:0] alu_a_out, alu_b_out, ex_rs2_data_out, ex_pc_out;
    logic [4:0]  ex_rd_addr_out;
    logic        ex_reg_we_out;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid_in(id_valid_in), .id_ready_out(id_ready_out),
        .id_pc_in(id_pc_in), .id_rs1_data_in(id_rs1_data_in),
        .id_rs2_data_in(id_rs2_data_in), .id_imm_in(id_imm_in),
        .id_rs1_addr_in(id_rs1_addr_in), .id_rs2_addr_in(id_rs2_addr_in),
        .id_rd_addr_in(id_rd_addr_in), .id_alu_ctrl_in(id_alu_ctrl_in),
        .id_a_sel_in(id_a_sel_in), .id_b_sel_in(id_b_sel_in),
        .id_reg_we_in(id_reg_we_in), .flush_in(flush_in),
        .ex_ready_in(ex_ready_in),
        .exm_rd_addr_in(exm_rd_addr_in), .exm_reg_we_in(exm_reg_we_in),
        .exm_result_in(exm_result_in),
        .wb_rd_addr_in(wb_rd_addr_in), .wb_reg_we_in(wb_reg_we_in),
        .wb_data_in(wb_data_in),
        .ex_valid_out(ex_valid_out), .alu_ctrl_out(alu_ctrl_out),
        .alu_a_out(alu_a_out), .alu_b_out(alu_b_out),
        .ex_rs2_data_out(ex_rs2_data_out), .ex_pc_out(ex_pc_out),
        .ex_rd_addr_out(ex_rd_addr_out), .ex_reg_we_out(ex_reg_we_out)
    );

    always #5 clk = ~clk;

`ifdef FRISCV_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the instruction currently held by the stage.
    typedef struct {
        bit          valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1a, rs2a, rd;
        logic [3:0]  ctrl;
        bit          asel, bsel, we;
    } instr_t;

    instr_t held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Value the ALU should see for a source register, from the current later-stage buses.
    function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] d);
        if (FWD && a != 5'd0 && exm_reg_we_in && exm_rd_addr_in == a) return exm_result_in;
        if (FWD && a != 5'd0 && wb_reg_we_in && wb_rd_addr_in == a)   return wb_data_in;
        return d;
    endfunction

    task automatic check_model();
        logic [31:0] src1, src2;
        src1 = operand(held.rs1a, held.rs1d);
        src2 = operand(held.rs2a, held.rs2d);
        check("ready", {31'd0, id_ready_out}, {31'd0, !held.valid || ex_ready_in});
        check("valid", {31'd0, ex_valid_out}, {31'd0, held.valid});
        check("reg_we", {31'd0, ex_reg_we_out}, {31'd0, held.valid && held.we});
        if (held.valid) begin
            check("ctrl", {28'd0, alu_ctrl_out}, {28'd0, held.ctrl});
            check("alu_a", alu_a_out, held.asel ? held.pc : src1);
            check("alu_b", alu_b_out, held.bsel ? held.imm : src2);
            check("rs2", ex_rs2_data_out, src2);
            check("pc", ex_pc_out, held.pc);
            check("rd", {27'd0, ex_rd_addr_out}, {27'd0, held.rd});
        end
    endtask

    task automatic model_edge();
        bit accept;
        accept = id_valid_in && (!held.valid || ex_ready_in);
        if (flush_in) held.valid = 1'b0;
        else if (accept) begin
            held.valid = 1'b1;
            held.pc = id_pc_in;   held.rs1d = id_rs1_data_in; held.rs2d = id_rs2_data_in;
            held.imm = id_imm_in; held.rs1a = id_rs1_addr_in; held.rs2a = id_rs2_addr_in;
            held.rd = id_rd_addr_in; held.ctrl = id_alu_ctrl_in;
            held.asel = id_a_sel_in; held.bsel = id_b_sel_in; held.we = id_reg_we_in;
        end else if (ex_ready_in) held.valid = 1'b0;
    endtask

    // Called just after a negedge with inputs already applied.
    task automatic cycle();
        #1;
        check_model();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_valid_in = 0; id_pc_in = 0; id_rs1_data_in = 0; id_rs2_data_in = 0; id_imm_in = 0;
        id_rs1_addr_in = 0; id_rs2_addr_in = 0; id_rd_addr_in = 0; id_alu_ctrl_in = 0;
        id_a_sel_in = 0; id_b_sel_in = 0; id_reg_we_in = 0; flush_in = 0; ex_ready_in = 1;
        exm_rd_addr_in = 0; exm_reg_we_in = 0; exm_result_in = 0;
        wb_rd_addr_in = 0; wb_reg_we_in = 0; wb_data_in = 0;
    endtask

    task automatic issue(input logic [3:0] ctrl, input logic [4:0] rs1a, input logic [31:0] rs1d,
                         input logic [31:0] imm, input bit bsel, input logic [31:0] pc);
        id_valid_in = 1; id_alu_ctrl_in = ctrl; id_rs1_addr_in = rs1a; id_rs1_data_in = rs1d;
        id_imm_in = imm; id_b_sel_in = bsel; id_a_sel_in = 0; id_pc_in = pc;
        id_rs2_addr_in = 5'd7; id_rs2_data_in = 32'h77; id_rd_addr_in = 5'd9; id_reg_we_in = 1;
    endtask

    initial begin
        held = '{default: '0};
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_valid", {31'd0, ex_valid_out}, 32'd0);
        check("rst_ready", {31'd0, id_ready_out}, 32'd1);
        check("rst_we", {31'd0, ex_reg_we_out}, 32'd0);
        check("rst_ctrl", {28'd0, alu_ctrl_out}, 32'd0);
        check("rst_a", alu_a_out, 32'd0);
        rst = 0;
        @(negedge clk);

        // Load an ADD with immediate B.
        issue(4'd3, 5'd5, 32'h10, 32'h4, 1'b1, 32'h100);
        cycle();
        id_valid_in = 0;
        #1;
        check("load_a", alu_a_out, 32'h10);
        check("load_b", alu_b_out, 32'h4);
        check("load_valid", {31'd0, ex_valid_out}, 32'd1);

        // Stall: downstream busy while a new instruction waits.
        ex_ready_in = 0;
        issue(4'd4, 5'd6, 32'h20, 32'h8, 1'b0, 32'h104);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ready", {31'd0, id_ready_out}, 32'd0);
            check("stall_a", alu_a_out, 32'h10);
            check("stall_b", alu_b_out, 32'h4);
            cycle();
        end
        ex_ready_in = 1;
        cycle();
        id_valid_in = 0;
        #1;
        check("release_a", alu_a_out, 32'h20);
        check("release_pc", ex_pc_out, 32'h104);
        check("release_ctrl", {28'd0, alu_ctrl_out}, 32'd4);
        cycle();

        // Flush alongside a load drops the instruction.
        issue(4'd0, 5'd1, 32'h33, 32'h0, 1'b0, 32'h200);
        flush_in = 1;
        cycle();
        flush_in = 0; id_valid_in = 0;
        #1;
        check("flush_valid", {31'd0, ex_valid_out}, 32'd0);
        check("flush_we", {31'd0, ex_reg_we_out}, 32'd0);

        // Forwarding priority on rs1=3.
        issue(4'd3, 5'd3, 32'h11, 32'h0, 1'b0, 32'h300);
        cycle();
        id_valid_in = 0; ex_ready_in = 0;
        exm_rd_addr_in = 5'd3; exm_reg_we_in = 1; exm_result_in = 32'hAA;
        wb_rd_addr_in = 5'd3; wb_reg_we_in = 1; wb_data_in = 32'hBB;
        #1;
        check("fwd_exm", alu_a_out, FWD ? 32'hAA : 32'h11);
        exm_reg_we_in = 0;
        #1;
        check("fwd_wb", alu_a_out, FWD ? 32'hBB : 32'h11);
        ex_ready_in = 1;
        cycle();

        // x0 is never forwarded.
        idle_inputs();
        issue(4'd3, 5'd0, 32'h22, 32'h0, 1'b0, 32'h400);
        cycle();
        id_valid_in = 0; ex_ready_in = 0;
        exm_rd_addr_in = 5'd0; exm_reg_we_in = 1; exm_result_in = 32'hAA;
        #1;
        check("x0_a", alu_a_out, 32'h22);
        ex_ready_in = 1;
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            id_valid_in    = ($urandom_range(0, 3) != 0);
            id_pc_in       = $urandom;
            id_rs1_data_in = $urandom;
            id_rs2_data_in = $urandom;
            id_imm_in      = $urandom;
            id_rs1_addr_in = 5'($urandom_range(0, 3));
            id_rs2_addr_in = 5'($urandom_range(0, 3));
            id_rd_addr_in  = 5'($urandom_range(0, 31));
            id_alu_ctrl_in = 4'($urandom_range(0, 8));
            id_a_sel_in    = 1'($urandom_range(0, 1));
            id_b_sel_in    = 1'($urandom_range(0, 1));
            id_reg_we_in   = 1'($urandom_range(0, 1));
            flush_in       = ($urandom_range(0, 9) == 0);
            ex_ready_in    = ($urandom_range(0, 2) != 0);
            exm_rd_addr_in = 5'($urandom_range(0, 3));
            exm_reg_we_in  = 1'($urandom_range(0, 1));
            exm_result_in  = $urandom;
            wb_rd_addr_in  = 5'($urandom_range(0, 3));
            wb_reg_we_in   = 1'($urandom_range(0, 1));
            wb_data_in     = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
